// File: rtl/bp_fe_ptw_dual_issue.sv
// Sv39 instruction-side page-table walker for the dual-issue front end.
// Queues up to two I-TLB misses, walks each through memory one PTE at a
// time, and returns a single-cycle TLB fill or instruction page fault.
// Optional build macro: BP_PTW_AD_FAULT_EN - a leaf with A=0 faults.
module bp_fe_ptw_dual_issue #(
  parameter int vtag_width_p  = 27,
  parameter int ptag_width_p  = 28,
  parameter int paddr_width_p = 40,
  parameter int entry_width_p = 35
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  input  logic [ptag_width_p-1:0]  satp_ppn_i,
  input  logic                     miss_v_i1,
  input  logic [vtag_width_p-1:0]  miss_vtag_i1,
  input  logic                     miss_v_i2,
  input  logic [vtag_width_p-1:0]  miss_vtag_i2,
  output logic                     busy_o,
  output logic                     mem_req_v_o,
  output logic [paddr_width_p-1:0] mem_req_paddr_o,
  input  logic                     mem_req_ready_i,
  input  logic                     mem_resp_v_i,
  input  logic [63:0]              mem_resp_data_i,
  output logic                     w_v_o,
  output logic [vtag_width_p-1:0]  w_vtag_o,
  output logic [entry_width_p-1:0] w_entry_o,
  output logic                     fault_v_o,
  output logic [vtag_width_p-1:0]  fault_vtag_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]               state;
  logic [1:0]               level;
  logic [ptag_width_p-1:0]  ppn;
  logic [vtag_width_p-1:0]  vtag_r;
  logic [entry_width_p-1:0] entry_r;
  logic                     fault_r;
  logic                     abort_r;   // flushed while a response is still owed

  logic [vtag_width_p-1:0]  q_vtag0, q_vtag1;
  logic [1:0]               q_cnt;

  // PTE field decode
  logic                    pte_v, pte_r, pte_w, pte_x, pte_u, pte_a, pte_d;
  logic [ptag_width_p-1:0] pte_ppn;
  logic                    pte_ptr;
  logic                    pte_fault;
  logic                    leaf_giga;
  logic [ptag_width_p-1:0] leaf_ptag;
  logic [8:0]              vpn;
  logic                    unused_pte_bits;

  assign pte_v   = mem_resp_data_i[0];
  assign pte_r   = mem_resp_data_i[1];
  assign pte_w   = mem_resp_data_i[2];
  assign pte_x   = mem_resp_data_i[3];
  assign pte_u   = mem_resp_data_i[4];
  assign pte_a   = mem_resp_data_i[6];
  assign pte_d   = mem_resp_data_i[7];
  assign pte_ppn = mem_resp_data_i[10 +: ptag_width_p];
  assign pte_ptr = ~pte_r & ~pte_x;
  assign unused_pte_bits = ^{mem_resp_data_i[63:10+ptag_width_p], mem_resp_data_i[9:8],
                             mem_resp_data_i[5]};

  assign busy_o = (state != IDLE) || (q_cnt != 2'd0);

  // Select the VPN field indexed by the current level
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    vpn = vtag_r[8:0];
    case (level)
      2'd2:    vpn = vtag_r[26:18];
      2'd1:    vpn = vtag_r[17:9];
      default: vpn = vtag_r[8:0];
    endcase
  end

  // Classify the returned PTE and build the leaf ptag for the current level
  always_comb begin
    pte_fault = 1'b0;
    leaf_giga = 1'b0;
    leaf_ptag = pte_ppn;
    if (!pte_v || (!pte_r && pte_w)) begin
      pte_fault = 1'b1;
    end else if (pte_ptr) begin
      pte_fault = (level == 2'd0);
    end else begin
      if (!pte_x) pte_fault = 1'b1;
      case (level)
        2'd2: begin
          if (pte_ppn[17:0] != '0) pte_fault = 1'b1;
          leaf_giga = 1'b1;
          leaf_ptag = {pte_ppn[ptag_width_p-1:18], vtag_r[17:0]};
        end
        2'd1: begin
          if (pte_ppn[8:0] != '0) pte_fault = 1'b1;
          leaf_ptag = {pte_ppn[ptag_width_p-1:9], vtag_r[8:0]};
        end
        default: leaf_ptag = pte_ppn;
      endcase
`ifdef BP_PTW_AD_FAULT_EN
      if (!pte_a) pte_fault = 1'b1;
`endif
    end
  end

  // Walk FSM: latch head miss, issue PTE reads, descend or finish
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset_i) begin
      state   <= IDLE;
      level   <= 2'd0;
      ppn     <= '0;
      vtag_r  <= '0;
      entry_r <= '0;
      fault_r <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          abort_r <= 1'b0;
          if (!flush_i && q_cnt != 2'd0) begin
            vtag_r <= q_vtag0;
            level  <= 2'd2;
            ppn    <= satp_ppn_i;
            state  <= SEND;
          end
        end
        SEND: begin
          if (mem_req_ready_i) begin
            abort_r <= flush_i;
            state   <= WAIT;
          end else if (flush_i) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (mem_resp_v_i) begin
            if (abort_r || flush_i) begin
              state <= IDLE;
            end else if (!pte_fault && pte_ptr) begin
              ppn   <= pte_ppn;
              level <= level - 2'd1;
              state <= SEND;
            end else begin
              fault_r <= pte_fault;
              entry_r <= {leaf_ptag, leaf_giga, pte_a, pte_d, pte_u, pte_x, pte_w, pte_r};
              state   <= DONE;
            end
          end else if (flush_i) begin
            abort_r <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry miss queue: fill only when fully idle, pop on completion
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: the queue is only two flops wide, so it is reset like ordinary state.
    if (reset_i) begin
      q_vtag0 <= '0;
      q_vtag1 <= '0;
      q_cnt   <= 2'd0;
    end else if (flush_i) begin
      q_cnt <= 2'd0;
    end else if (state == DONE) begin
      q_vtag0 <= q_vtag1;
      q_cnt   <= q_cnt - 2'd1;
    end else if (!busy_o) begin
      if (miss_v_i1 && miss_v_i2) begin
        q_vtag0 <= miss_vtag_i1;
        q_vtag1 <= miss_vtag_i2;
        q_cnt   <= (miss_vtag_i1 == miss_vtag_i2) ? 2'd1 : 2'd2;
      end else if (miss_v_i1) begin
        q_vtag0 <= miss_vtag_i1;
        q_cnt   <= 2'd1;
      end else if (miss_v_i2) begin
        q_vtag0 <= miss_vtag_i2;
        q_cnt   <= 2'd1;
      end
    end
  end

  // Outputs: request during SEND, single-cycle strobe in DONE unless flushed
  always_comb begin
    mem_req_v_o     = (state == SEND);
    mem_req_paddr_o = '0;
    if (state == SEND) mem_req_paddr_o = {ppn, vpn, 3'b000};
    w_v_o        = (state == DONE) && !flush_i && !fault_r;
    fault_v_o    = (state == DONE) && !flush_i &&  fault_r;
    w_vtag_o     = w_v_o     ? vtag_r  : '0;
    w_entry_o    = w_v_o     ? entry_r : '0;
    fault_vtag_o = fault_v_o ? vtag_r  : '0;
  end

endmodule
